// File: rtl/ram_rw_check.sv
// ram_rw_check: write/read-back self-test for a single-port block RAM.
// Writes DEPTH words of (addr + SEED) to the RAM, reads them back, and checks
// each returned word. The RAM's read latency is RD_LAT.
// Ports:
//   sys_clk, sys_rst_n      - clock, asynchronous active-low reset
//   start                   - one-cycle pulse that starts a pass
//   ram_en/we/addr/din      - RAM native port controls (all registered)
//   ram_dout                - RAM read data
//   busy, done              - pass in progress / pass finished (held)
//   err, err_cnt            - sticky mismatch flag, saturating mismatch count
//   first_err_addr          - address of the first mismatch in the pass
// Optional build macro RW_LOOP_EN: passes repeat back to back, done pulses for
// one cycle between them, start is ignored after the first pass, and the error
// results accumulate until reset.
module ram_rw_check #(
    parameter int AW     = 5,
    parameter int DW     = 8,
    parameter int DEPTH  = 32,
    parameter int SEED   = 0,
    parameter int RD_LAT = 1,
    parameter int ERR_W  = 16
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             start,
    output logic             ram_en,
    output logic             ram_we,
    output logic [AW-1:0]    ram_addr,
    output logic [DW-1:0]    ram_din,
    input  logic [DW-1:0]    ram_dout,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [ERR_W-1:0] err_cnt,
    output logic [AW-1:0]    first_err_addr
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] WRITE = 3'd1;
    localparam logic [2:0] READ  = 3'd2;
    localparam logic [2:0] DRAIN = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;
    localparam int DCW = $clog2(RD_LAT) + 1;
    localparam logic [AW-1:0]  LAST   = AW'(DEPTH - 1);
    localparam logic [DCW-1:0] DLAST  = DCW'(RD_LAT - 1);
    localparam logic [DW-1:0]  SEED_W = DW'(SEED);

    logic [2:0]       state_q, state_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [DCW-1:0]   drain_q, drain_d;
    logic             en_q, we_q, busy_q, done_q, err_q, err_d;
    logic [DW-1:0]    din_q;
    logic [ERR_W-1:0] cnt_q, cnt_d;
    logic [AW-1:0]    fea_q, fea_d;
    logic [RD_LAT-1:0] vld_q;
    logic [DW-1:0]    exp_q [RD_LAT];
    logic [AW-1:0]    pa_q [RD_LAT];
    logic             clr, hit;

    assign ram_en         = en_q;
    assign ram_we         = we_q;
    assign ram_addr       = addr_q;
    assign ram_din        = din_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign err            = err_q;
    assign err_cnt        = cnt_q;
    assign first_err_addr = fea_q;

    // The oldest pipeline entry lines up with the RAM data for its address.
    assign hit = vld_q[RD_LAT-1] && (ram_dout != exp_q[RD_LAT-1]);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        drain_d = drain_q;
        clr     = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                state_d = WRITE;
                addr_d  = '0;
                clr     = 1'b1;
            end
            WRITE: begin
                state_d = (addr_q == LAST) ? READ : WRITE;
                addr_d  = (addr_q == LAST) ? '0 : addr_q + AW'(1);
            end
            READ: begin
                state_d = (addr_q == LAST) ? DRAIN : READ;
                addr_d  = (addr_q == LAST) ? '0 : addr_q + AW'(1);
                drain_d = '0;
            end
            DRAIN: begin
                state_d = (drain_q == DLAST) ? DONE : DRAIN;
                drain_d = drain_q + DCW'(1);
            end
            DONE: begin
`ifdef RW_LOOP_EN
                state_d = WRITE;
                addr_d  = '0;
`else
                if (start) begin
                    state_d = WRITE;
                    addr_d  = '0;
                    clr     = 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
        err_d = clr ? 1'b0 : (err_q | hit);
        cnt_d = clr ? '0 : (hit && !(&cnt_q)) ? cnt_q + ERR_W'(1) : cnt_q;
        fea_d = clr ? '0 : (hit && !err_q) ? pa_q[RD_LAT-1] : fea_q;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            drain_q <= '0;
            en_q    <= 1'b0;
            we_q    <= 1'b0;
            din_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            fea_q   <= '0;
            vld_q   <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                exp_q[i] <= '0;
                pa_q[i]  <= '0;
            end
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            drain_q <= drain_d;
            en_q    <= (state_d == WRITE) || (state_d == READ);
            we_q    <= (state_d == WRITE);
            din_q   <= (state_d == WRITE) ? DW'(addr_d) + SEED_W : '0;
            busy_q  <= (state_d == WRITE) || (state_d == READ) || (state_d == DRAIN);
            done_q  <= (state_d == DONE);
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            fea_q   <= fea_d;
            // A read is issued on the edge where the RAM samples en/addr.
            vld_q[0] <= en_q && !we_q;
            exp_q[0] <= DW'(addr_q) + SEED_W;
            pa_q[0]  <= addr_q;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                exp_q[i] <= exp_q[i-1];
                pa_q[i]  <= pa_q[i-1];
            end
        end
    end
endmodule

// File: tb/tb_ram_rw_check.sv
// tb_ram_rw_check: randomized self-check of ram_rw_check against RAM models.
module tb_ram_rw_check;
    localparam int D  = 32;
    localparam int LA = 1;
    localparam int LB = 2;
    localparam int SA = 0;
    localparam int SB = 'hF0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic scr = 1'b0;
    logic [1:0] en, we, busy, done, err;
    logic [4:0] addr [2];
    logic [7:0] din [2];
    logic [7:0] dout [2];
    logic [15:0] cnt [2];
    logic [4:0] fea [2];
    logic [7:0] mem [2][32];
    logic [31:0] bad [2];
    logic [7:0] r1b;
    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    ram_rw_check #(.SEED(SA), .RD_LAT(LA)) u_a (
        .sys_clk(clk), .sys_rst_n(rst_n), .start(start),
        .ram_en(en[0]), .ram_we(we[0]), .ram_addr(addr[0]), .ram_din(din[0]),
        .ram_dout(dout[0]), .busy(busy[0]), .done(done[0]), .err(err[0]),
        .err_cnt(cnt[0]), .first_err_addr(fea[0])
    );

    ram_rw_check #(.SEED(SB), .RD_LAT(LB)) u_b (
        .sys_clk(clk), .sys_rst_n(rst_n), .start(start),
        .ram_en(en[1]), .ram_we(we[1]), .ram_addr(addr[1]), .ram_din(din[1]),
        .ram_dout(dout[1]), .busy(busy[1]), .done(done[1]), .err(err[1]),
        .err_cnt(cnt[1]), .first_err_addr(fea[1])
    );

    // RAM models: a is unregistered (latency 1), b has an output register
    // (latency 2). Addresses flagged in bad[] return 0xAA on read.
    always @(posedge clk) begin
        if (scr) begin
            for (int i = 0; i < 32; i++) begin
                mem[0][i] <= 8'(~i);
                mem[1][i] <= 8'(~i);
            end
        end else begin
            if (en[0] && we[0]) mem[0][addr[0]] <= din[0];
            if (en[1] && we[1]) mem[1][addr[1]] <= din[1];
        end
        if (en[0] && !we[0]) dout[0] <= bad[0][addr[0]] ? 8'hAA : mem[0][addr[0]];
        if (en[1] && !we[1]) r1b <= bad[1][addr[1]] ? 8'hAA : mem[1][addr[1]];
        dout[1] <= r1b;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic int first_set(input logic [31:0] m);
        for (int i = 0; i < 32; i++) if (m[i]) return i;
        return 0;
    endfunction

    function automatic logic [31:0] rnd_mask();
        logic [31:0] m = '0;
        repeat ($urandom_range(0, 3)) m[$urandom_range(0, 31)] = 1'b1;
        return m;
    endfunction

    task automatic run_pass(input logic [31:0] ba, input logic [31:0] bb, input bit jab);
        int td[2];
        int wr[2];
        int rd[2];
        int mm;
        logic [31:0] bm[2];
        td = '{0, 0};
        wr = '{0, 0};
        rd = '{0, 0};
        bm = '{ba, bb};
        bad[0] = ba;
        bad[1] = bb;
        scr = 1'b1;
        @(posedge clk); #1 scr = 1'b0;
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int n = 1; n <= 200 && (td[0] == 0 || td[1] == 0); n++) begin
            for (int k = 0; k < 2; k++) begin
                if (en[k] && we[k]) wr[k]++;
                if (en[k] && !we[k]) rd[k]++;
                if (done[k] && td[k] == 0) td[k] = n;
            end
            if (n == 1) chk("first_cycle", {busy, en, we, done}, 8'hFC);
            if (jab && n >= 36 && n <= 60) start = ($urandom % 3 == 0);
            @(posedge clk); #1 start = 1'b0;
        end
        chk("a_done_cycle", td[0], 2 * D + LA + 1);
        chk("b_done_cycle", td[1], 2 * D + LB + 1);
        for (int k = 0; k < 2; k++) begin
            mm = 0;
            for (int i = 0; i < 32; i++) if (mem[k][i] !== 8'(i + (k ? SB : SA))) mm++;
            chk($sformatf("wr_rd_count_%0d", k), (wr[k] << 8) | rd[k], (D << 8) | D);
            chk($sformatf("mem_pattern_%0d", k), mm, 0);
            chk($sformatf("err_%0d", k), err[k], bm[k] != 0);
            chk($sformatf("err_cnt_%0d", k), cnt[k], $countones(bm[k]));
            chk($sformatf("first_err_%0d", k), fea[k], first_set(bm[k]));
        end
        repeat (3) @(posedge clk);
        #1 chk("done_hold", {done, busy, en}, 6'b110000);
    endtask

    task automatic do_reset_release();
        repeat (2) @(posedge clk);
        #4 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
    endtask

`ifdef RW_LOOP_EN
    task automatic loop_test();
        int r[2][3];
        int nr[2];
        logic pd[2];
        int wide;
        r = '{'{0, 0, 0}, '{0, 0, 0}};
        nr = '{0, 0};
        pd = '{1'b0, 1'b0};
        wide = 0;
        bad[0] = 32'h80;
        bad[1] = 32'h80;
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int n = 1; n <= 210; n++) begin
            for (int k = 0; k < 2; k++) begin
                if (done[k] && !pd[k] && nr[k] < 3) begin
                    r[k][nr[k]] = n;
                    nr[k]++;
                end
                if (done[k] && pd[k]) wide++;
                pd[k] = done[k];
            end
            if (n == 70) begin
                bad[0] = '0;
                bad[1] = '0;
            end
            start = (n == 100);
            @(posedge clk); #1 start = 1'b0;
        end
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 3; i++)
                chk($sformatf("loop_done_%0d_%0d", k, i), r[k][i], (i + 1) * (2 * D + (k ? LB : LA) + 1));
        chk("loop_pulse_width", wide, 0);
        chk("loop_err_cnt_a", cnt[0], 1);
        chk("loop_err_cnt_b", cnt[1], 1);
        chk("loop_first_err", {err, fea[0], fea[1]}, {2'b11, 5'd7, 5'd7});
    endtask
`endif

    initial begin
        bad[0] = '0;
        bad[1] = '0;
        repeat (3) @(posedge clk);
        #1 chk("reset_state", |{en, we, busy, done, err, addr[0], addr[1], din[0], din[1],
                                 cnt[0], cnt[1], fea[0], fea[1]}, 0);
        #3 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1 chk("idle_no_start", {busy, en}, 0);
`ifdef RW_LOOP_EN
        loop_test();
`else
        run_pass(0, 0, 0);
        run_pass((32'd1 << 5) | (32'd1 << 9), 32'd1 << 31, 0);
        chk("b_mem0", mem[1][0], 8'hF0);
        chk("b_mem16", mem[1][16], 8'h00);
        run_pass(0, 32'd1 << 3, 1);
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #1 chk("pre_rst_addr", {we[0], addr[0]}, {1'b1, 5'd10});
        #1 rst_n = 1'b0;
        #1 chk("rst_async_zero", |{en, we, busy, done, err, addr[0], addr[1], din[0], din[1],
                                    cnt[0], cnt[1], fea[0], fea[1]}, 0);
        do_reset_release();
        chk("idle_after_rst", {busy, en, done}, 0);
        bad[0] = 32'd1 << 5;
        bad[1] = 32'd1 << 5;
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (38) @(posedge clk);
        #1 chk("pre_flush_err", err, 0);
        #1 rst_n = 1'b0;
        do_reset_release();
        chk("flush_err", {err, busy}, 0);
        chk("flush_cnt", cnt[0] | cnt[1], 0);
        run_pass(0, 0, 0);
        repeat (4) run_pass(rnd_mask(), rnd_mask(), 1'($urandom % 2));
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
